tolower_stream: RTL and testbench
=================================

TOLOWER_STREAM -- requirements
Module: tolower_stream

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of converted-character counter.
REQ-002 SHALL have port clk, input, 1: single clock, all state rising-edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port in_data, input, 8: ASCII byte offered by upstream.
REQ-005 SHALL have port in_valid, input, 1: in_data valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept a byte this cycle.
REQ-007 SHALL have port out_data, output, 8: converted byte at buffer head.
REQ-008 SHALL have port out_valid, output, 1: out_data valid.
REQ-009 SHALL have port out_ready, input, 1: downstream accepts out_data.
REQ-010 SHALL have port en, input, 1: 1 = convert, 0 = pass bytes unchanged.
REQ-011 SHALL have port cnt_clr, input, 1: synchronous clear of conv_count.
REQ-012 SHALL have port conv_count, output, CNT_W: number of bytes converted since reset/clear.

Function
REQ-013 SHALL accept a byte (push) on a rising edge where in_valid=1 and in_ready=1.
REQ-014 SHALL deliver a byte (pop) on a rising edge where out_valid=1 and out_ready=1.
REQ-015 SHALL convert at push time: if en=1 and in_data in 0x41..0x5A, stored byte = in_data with bit 5 set (+0x20); otherwise stored byte = in_data unchanged.
REQ-016 SHALL treat 0x40, 0x5B, 0x61..0x7A, and 0x80..0xFF as non-letters (unchanged, not counted).
REQ-017 SHALL buffer bytes in a 2-entry in-order FIFO; no byte dropped, duplicated or reordered.
REQ-018 SHALL implement occupancy state machine EMPTY(0), HALF(1), FULL(2).
REQ-019 EMPTY: push -> HALF; no push -> EMPTY.
REQ-020 HALF: push only -> FULL; pop only -> EMPTY; push and pop together -> HALF.
REQ-021 FULL: pop -> HALF; no pop -> FULL; push impossible.
REQ-022 SHALL drive in_ready=1 in EMPTY and HALF, 0 in FULL; in_ready SHALL NOT depend combinationally on out_ready.
REQ-023 SHALL drive out_valid=1 in HALF and FULL, 0 in EMPTY; out_data = oldest stored byte.
REQ-024 SHALL have latency of exactly 1 cycle: a byte pushed at edge N into EMPTY is on out_data with out_valid=1 after edge N; no combinational in->out bypass.
REQ-025 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-026 SHALL sample en per byte at its push edge; changing en does not alter already-buffered bytes.
REQ-027 SHALL increment conv_count by 1 on each push where a conversion occurs (REQ-015).
REQ-028 SHALL saturate conv_count at 2^CNT_W-1; no wrap to 0.
REQ-029 SHALL set conv_count to 0 on an edge with cnt_clr=1; clear takes priority over a simultaneous increment (result 0).
REQ-030 SHALL ignore in_data and en when in_valid=0 or in_ready=0.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force state EMPTY, in_ready=0, out_valid=0, out_data=0x00, conv_count=0.
REQ-032 SHALL drive in_ready=1 from the first rising edge after rst_n deasserts.
REQ-033 SHALL discard any buffered bytes when reset asserts mid-operation; none appear after release.

Verification
REQ-034 Bench SHALL push "Hello, WORLD!" with en=1, out_ready=1 -> out stream "hello, world!", conv_count=6, each byte 1 cycle after push.
REQ-035 Bench SHALL push 0x40, 0x41, 0x5A, 0x5B, 0x61, 0xC1 with en=1 -> out 0x40, 0x61, 0x7A, 0x5B, 0x61, 0xC1, conv_count=2.
REQ-036 Bench SHALL hold out_ready=0 and push 0x41, 0x42, 0x43 -> first two accepted, in_ready=0 in FULL, 0x43 held; after out_ready=1, out 0x61, 0x62, 0x63 in order.
REQ-037 Bench SHALL push "AB" with en=0 then "AB" with en=1 -> out 0x41, 0x42, 0x61, 0x62, conv_count=2.
REQ-038 Bench SHALL use CNT_W=2 and push 5 uppercase bytes -> conv_count 1,2,3,3,3; cnt_clr=1 on same edge as a 6th uppercase push -> conv_count=0.
REQ-039 Bench SHALL assert rst_n=0 with FULL buffer -> out_valid=0, conv_count=0 immediately; after release, no stale bytes output.

Source files
------------

// File: rtl/tolower_stream.sv
// Byte stream that lowercases ASCII A-Z through a 2-entry in-order FIFO.
// It also keeps a saturating count of how many bytes it has converted.
`timescale 1ns/1ps
module tolower_stream #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             en,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] conv_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             rdy_q;
  logic [7:0]       mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;
  logic [7:0]       conv_byte;
  logic             is_upper;

  function automatic logic upper_letter(input logic [7:0] b);
    return (b >= 8'h41) && (b <= 8'h5A);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_W'(1);
  endfunction

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign is_upper  = en & upper_letter(in_data);
  assign conv_byte = is_upper ? (in_data | 8'h20) : in_data;

  // State register; rdy_q keeps in_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (push) state_d = HALF;
      HALF: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:  if (pop) state_d = HALF;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = rdy_q && (state_q != FULL);
    out_valid = (state_q != EMPTY);
    out_data  = mem_q[rd_ptr_q];
  end

  // Storage and pointers; storage is reset so out_data reads 0x00 while held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= 8'h00;
      mem_q[1] <= 8'h00;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= conv_byte;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Clear wins over a same-edge increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)               cnt_d = '0;
    else if (push && is_upper) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign conv_count = cnt_q;

endmodule

// File: tb/tb_tolower_stream.sv
// Scoreboard bench for tolower_stream: a driver queues expected bytes at push,
// a negedge monitor compares and retires them as the DUT presents them.
`timescale 1ns/1ps
module tb_tolower_stream;

  logic        clk, rst_n;
  logic [7:0]  in_data;
  logic        in_valid, out_ready, en, cnt_clr;
  logic        in_ready, out_valid;
  logic [7:0]  out_data;
  logic [15:0] conv_count;
  logic        in_ready_s, out_valid_s;
  logic [7:0]  out_data_s;
  logic [1:0]  conv_count_s;

  tolower_stream dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .en(en), .cnt_clr(cnt_clr), .conv_count(conv_count)
  );

  tolower_stream #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_s), .out_data(out_data_s), .out_valid(out_valid_s),
    .out_ready(out_ready), .en(en), .cnt_clr(cnt_clr), .conv_count(conv_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] q[$];
  bit         mon_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: runs at negedge, retires the head when a pop will occur on the next edge.
  initial begin
    wait (mon_on);
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        chk("out_valid", {31'b0, out_valid}, 32'd1);
        chk("out_data", {24'b0, out_data}, {24'b0, q[0]});
        if (out_valid && out_ready) void'(q.pop_front());
      end else begin
        chk("no_stale_valid", {31'b0, out_valid}, 32'd0);
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [7:0] exp, input logic e);
    bit acc;
    acc = 0;
    in_data  = d;
    en       = e;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = in_ready;
      @(posedge clk);
      if (acc) q.push_back(exp);
      #2;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
  endtask

  task automatic drain(input string name);
    idle();
    out_ready = 1'b1;
    tick(4);
    chk(name, q.size(), 32'd0);
  endtask

  initial begin
    string      s_in, s_exp;
    logic [7:0] v_in  [6];
    logic [7:0] v_exp [6];
    logic [1:0] sat_exp [5];

    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    en = 1'b0; cnt_clr = 1'b0;
    tick(2);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", {24'b0, out_data}, 32'h00);
    chk("rst_count", {16'b0, conv_count}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_edge", {31'b0, in_ready}, 32'd0);
    tick(1);
    chk("in_ready_after_release", {31'b0, in_ready}, 32'd1);
    mon_on = 1;

    // Mixed-case string, streaming at full rate.
    out_ready = 1'b1;
    s_in = "Hello, WORLD!";
    s_exp = "hello, world!";
    for (int i = 0; i < s_in.len(); i++) send(s_in[i], s_exp[i], 1'b1);
    idle();
    drain("drain_hello");
    chk("count_hello", {16'b0, conv_count}, 32'd6);

    // Letter-range boundaries.
    clear_cnt();
    v_in  = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h61, 8'hC1};
    v_exp = '{8'h40, 8'h61, 8'h7A, 8'h5B, 8'h61, 8'hC1};
    for (int i = 0; i < 6; i++) send(v_in[i], v_exp[i], 1'b1);
    drain("drain_bounds");
    chk("count_bounds", {16'b0, conv_count}, 32'd2);

    // Backpressure: fill, hold a third byte, then release.
    clear_cnt();
    out_ready = 1'b0;
    send(8'h41, 8'h61, 1'b1);
    send(8'h42, 8'h62, 1'b1);
    in_valid = 1'b0;
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    in_data = 8'h43; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("held_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    send(8'h43, 8'h63, 1'b1);
    drain("drain_bp");
    chk("count_bp", {16'b0, conv_count}, 32'd3);

    // en sampled per byte.
    clear_cnt();
    send(8'h41, 8'h41, 1'b0);
    send(8'h42, 8'h42, 1'b0);
    send(8'h41, 8'h61, 1'b1);
    send(8'h42, 8'h62, 1'b1);
    drain("drain_en");
    chk("count_en", {16'b0, conv_count}, 32'd2);

    // Saturation on the 2-bit counter, then clear colliding with a push.
    clear_cnt();
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      send(8'h41 + 8'(i), 8'h61 + 8'(i), 1'b1);
      chk("sat_count", {30'b0, conv_count_s}, {30'b0, sat_exp[i]});
    end
    cnt_clr = 1'b1;
    send(8'h46, 8'h66, 1'b1);
    cnt_clr = 1'b0;
    chk("clr_over_inc_s", {30'b0, conv_count_s}, 32'd0);
    chk("clr_over_inc", {16'b0, conv_count}, 32'd0);
    drain("drain_sat");

    // Reset with a full buffer discards contents.
    clear_cnt();
    out_ready = 1'b0;
    send(8'h58, 8'h78, 1'b1);
    send(8'h59, 8'h79, 1'b1);
    idle();
    chk("pre_rst_count", {16'b0, conv_count}, 32'd2);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_count", {16'b0, conv_count}, 32'd0);
    chk("mid_rst_out_data", {24'b0, out_data}, 32'h00);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    tick(2);
    out_ready = 1'b1;
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    tick(5);
    chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("post_rst_queue", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
